pixel_addr_gen_up: RTL and testbench
====================================

# pixel_addr_gen_up

Ascending pixel-address generator for the orientation 0 and 45 paths. It emits frame-buffer addresses 0, 1, 2, … LAST, one per accepted beat on a valid/ready handshake. It is the ascending counterpart of the descending 1023→0 address counter used for orientations 180 and 225. It sits between the rotation control logic, which issues start/clear, and the frame-buffer access port, which consumes the addresses and applies back-pressure.

## Interface
Parameters:
- ADDR_W, 10, width of addr.
- LAST, 1023, terminal address of a frame pass. Must satisfy 0 ≤ LAST ≤ 2^ADDR_W − 1.
- FCNT_W, 8, width of frame_cnt.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request a frame pass. Sampled only in IDLE.
- clear  input  1  synchronous abort. Returns the block to IDLE.
- out_ready  input  1  consumer accepts addr this cycle.
- out_valid  output  1  addr is valid.
- addr  output  ADDR_W  current pixel address.
- addr_last  output  1  high when out_valid=1 and addr==LAST.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when a pass completes.
- frame_cnt  output  FCNT_W  number of completed passes; wraps modulo 2^FCNT_W.

## Operation
- All outputs are registered, except addr_last, which may be decoded from registered addr/out_valid.
- Reset (reset=0, asynchronous): state=IDLE, addr=0, out_valid=0, addr_last=0, busy=0, done=0, frame_cnt=0.
- Priority, highest first: reset, clear, normal FSM.
- clear=1 in any state, at the next edge: state=IDLE, addr=0, out_valid=0, done=0. frame_cnt is unchanged; only reset zeroes it.
- States:
  - IDLE: out_valid=0, addr=0. If start=1, go to RUN and set out_valid=1 with addr=0.
  - RUN: out_valid=1. A beat is accepted when out_valid && out_ready.
    - Accepted with addr<LAST: addr ← addr+1.
    - Accepted with addr==LAST: go to DONE and set out_valid=0. addr holds LAST.
    - Not accepted (stall): addr and out_valid hold. addr must never change while out_valid=1 and out_ready=0.
  - DONE: lasts exactly one cycle. done=1, and frame_cnt increments at the transition into DONE. Next state is IDLE with addr=0.
- start is ignored in RUN and DONE; it is not queued.
- Increment arithmetic is ADDR_W bits unsigned. addr never exceeds LAST, so no natural wrap occurs in a pass.
- LAST=0 gives a single-beat pass: addr=0 with addr_last=1 on the first valid cycle.
- frame_cnt wraps from 2^FCNT_W − 1 to 0 without any flag.

## Timing
- start sampled high in IDLE at edge n: out_valid=1, addr=0, busy=1 from cycle n+1.
- With out_ready held 1, addresses 0…LAST appear on consecutive cycles n+1…n+1+LAST. This is one address per cycle, with no bubbles.
- done=1 in cycle n+2+LAST. The block is back in IDLE (busy=0) in cycle n+3+LAST.
- Earliest accepted restart is start high in cycle n+3+LAST, giving the first address in n+4+LAST.
- Each cycle of out_ready=0 during RUN delays all later events by exactly one cycle.
- clear has one-cycle latency. In the cycle after clear is sampled: out_valid=0, busy=0, and no done pulse is produced for the aborted pass.
- Reset deassertion: the first start is honoured at the first rising edge after reset returns to 1.

## Test plan
- Reset values: hold reset=0 for 3 cycles with random inputs → out_valid=0, addr=0, busy=0, done=0, frame_cnt=0. Assert reset mid-RUN at addr=37 → all outputs return to reset values immediately, without waiting for a clock edge.
- Full pass, defaults, out_ready=1: pulse start at cycle 0 →
  - addr 0…1023 on cycles 1…1024;
  - addr_last=1 only at cycle 1024;
  - done=1 at cycle 1025;
  - frame_cnt=1;
  - busy=0 at cycle 1026.
- Back-pressure, LAST=5: toggle out_ready 1,0,0,1,… → each addr is held stable while stalled; the sequence is exactly 0,1,2,3,4,5 with no skips or repeats; done follows the acceptance of 5 by one cycle.
- clear mid-pass, LAST=5: assert clear while addr=3 → next cycle IDLE, addr=0, out_valid=0; no done pulse; frame_cnt unchanged. A following start restarts at addr 0.
- Ignored start and LAST=0: with LAST=0, pulse start → one beat with addr=0 and addr_last=1, then done. Start pulses during RUN/DONE produce no extra pass.
- frame_cnt wrap: with FCNT_W=2, run 5 passes → frame_cnt reads 1,2,3,0,1 after each done.

Source files
------------

// File: rtl/pixel_addr_gen_up.sv
// ---------------------------------------------------------------------------
// pixel_addr_gen_up
//
// Ascending frame-buffer address generator. After a start request it emits
// addresses 0, 1, ... LAST, one per accepted beat on an out_valid/out_ready
// handshake. It then produces a one-cycle done pulse, bumps the pass counter
// and returns to idle. This is the ascending twin of the descending 1023->0
// address counter.
//
// Parameters:
//   ADDR_W  width of addr
//   LAST    terminal address of a pass (0 <= LAST <= 2^ADDR_W-1)
//   FCNT_W  width of the completed-pass counter
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   start      request a pass (only looked at while idle)
//   clear      synchronous abort back to idle (frame_cnt is preserved)
//   out_ready  consumer accepts addr this cycle
//   out_valid  addr is valid
//   addr       current pixel address
//   addr_last  out_valid && addr == LAST
//   busy       high while a pass is running or finishing
//   done       one-cycle pulse when a pass completes
//   frame_cnt  number of completed passes, wraps silently
// ---------------------------------------------------------------------------
module pixel_addr_gen_up #(
    parameter int ADDR_W = 10,
    parameter int LAST   = 1023,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_last,
    output logic              busy,
    output logic              done,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_busy;
    logic                r_done;
    logic [FCNT_W-1:0]   r_fcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fcnt  <= '0;
        end else if (clear) begin
            // Abort: no done pulse and the pass is not counted.
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    r_addr  <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Only move on an accepted beat. addr is frozen during a
                    // stall so the consumer always sees a stable value.
                    if (r_valid && out_ready) begin
                        if (r_addr == LAST_ADDR) begin
                            // addr holds LAST through DONE.
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_fcnt  <= r_fcnt + 1'b1;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_addr  <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_addr  <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign addr      = r_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_cnt = r_fcnt;
    // Decoded from registered state, so it stays glitch-free relative to clk.
    assign addr_last = r_valid && (r_addr == LAST_ADDR);

endmodule

// File: tb/tb_pixel_addr_gen_up.sv
// ---------------------------------------------------------------------------
// tb_pixel_addr_gen_up
//
// Three instances share one clock and reset:
//   u_full : default parameters (LAST=1023), full pass and mid-run reset
//   u_l5   : LAST=5, back-pressure / clear / ignored start (table driven)
//   u_l0   : LAST=0, FCNT_W=2, single-beat passes and counter wrap
// Observed state is packed as {out_valid, addr, addr_last, busy, done, frame_cnt}.
// ---------------------------------------------------------------------------
module tb_pixel_addr_gen_up;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // u_full
    logic       f_start, f_clear, f_ready;
    logic       f_valid, f_last, f_busy, f_done;
    logic [9:0] f_addr;
    logic [7:0] f_fcnt;
    // u_l5
    logic       a_start, a_clear, a_ready;
    logic       a_valid, a_last, a_busy, a_done;
    logic [9:0] a_addr;
    logic [7:0] a_fcnt;
    // u_l0
    logic       z_start, z_clear, z_ready;
    logic       z_valid, z_last, z_busy, z_done;
    logic [9:0] z_addr;
    logic [1:0] z_fcnt;

    pixel_addr_gen_up u_full (
        .clk(clk), .reset(reset), .start(f_start), .clear(f_clear),
        .out_ready(f_ready), .out_valid(f_valid), .addr(f_addr),
        .addr_last(f_last), .busy(f_busy), .done(f_done), .frame_cnt(f_fcnt)
    );

    pixel_addr_gen_up #(.ADDR_W(10), .LAST(5), .FCNT_W(8)) u_l5 (
        .clk(clk), .reset(reset), .start(a_start), .clear(a_clear),
        .out_ready(a_ready), .out_valid(a_valid), .addr(a_addr),
        .addr_last(a_last), .busy(a_busy), .done(a_done), .frame_cnt(a_fcnt)
    );

    pixel_addr_gen_up #(.ADDR_W(10), .LAST(0), .FCNT_W(2)) u_l0 (
        .clk(clk), .reset(reset), .start(z_start), .clear(z_clear),
        .out_ready(z_ready), .out_valid(z_valid), .addr(z_addr),
        .addr_last(z_last), .busy(z_busy), .done(z_done), .frame_cnt(z_fcnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic st;
        logic cl;
        logic rdy;
        logic e_valid;
        int   e_addr;
        logic e_last;
        logic e_busy;
        logic e_done;
        int   e_fcnt;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(logic st, logic cl, logic rdy, logic v, int a,
                                logic l, logic b, logic d, int f);
        vec_t r;
        r.st = st; r.cl = cl; r.rdy = rdy;
        r.e_valid = v; r.e_addr = a; r.e_last = l;
        r.e_busy = b; r.e_done = d; r.e_fcnt = f;
        return r;
    endfunction

    function automatic logic [21:0] pk(logic v, int a, logic l, logic b,
                                       logic d, int f);
        return {v, a[9:0], l, b, d, f[7:0]};
    endfunction

    task automatic chk(input string name, input logic [21:0] act,
                       input logic [21:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got v=%0b addr=%0d last=%0b busy=%0b done=%0b fcnt=%0d, expected v=%0b addr=%0d last=%0b busy=%0b done=%0b fcnt=%0d",
                     name, act[21], act[20:11], act[10], act[9], act[8], act[7:0],
                     exp[21], exp[20:11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [21:0] f_obs, a_obs, z_obs;
    assign f_obs = {f_valid, f_addr, f_last, f_busy, f_done, f_fcnt};
    assign a_obs = {a_valid, a_addr, a_last, a_busy, a_done, a_fcnt};
    assign z_obs = {z_valid, z_addr, z_last, z_busy, z_done, 6'd0, z_fcnt};

    initial begin
        // ---------------- vector table for u_l5 (LAST=5) ----------------
        //                st cl rdy  v addr last busy done fcnt
        vecs[0]  = mk(1, 0, 0,  1, 0, 0, 1, 0, 0);  // start, stalled at 0
        vecs[1]  = mk(0, 0, 1,  1, 1, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0,  1, 1, 0, 1, 0, 0);  // stall
        vecs[3]  = mk(0, 0, 0,  1, 1, 0, 1, 0, 0);  // stall
        vecs[4]  = mk(0, 0, 1,  1, 2, 0, 1, 0, 0);
        vecs[5]  = mk(1, 0, 0,  1, 2, 0, 1, 0, 0);  // start in RUN ignored
        vecs[6]  = mk(0, 0, 0,  1, 2, 0, 1, 0, 0);
        vecs[7]  = mk(0, 0, 1,  1, 3, 0, 1, 0, 0);
        vecs[8]  = mk(0, 0, 1,  1, 4, 0, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0,  1, 4, 0, 1, 0, 0);
        vecs[10] = mk(0, 0, 1,  1, 5, 1, 1, 0, 0);
        vecs[11] = mk(0, 0, 0,  1, 5, 1, 1, 0, 0);  // stall on LAST
        vecs[12] = mk(0, 0, 1,  0, 5, 0, 1, 1, 1);  // DONE, addr holds LAST
        vecs[13] = mk(1, 0, 1,  0, 0, 0, 0, 0, 1);  // start in DONE ignored
        vecs[14] = mk(0, 0, 1,  0, 0, 0, 0, 0, 1);
        vecs[15] = mk(1, 0, 1,  1, 0, 0, 1, 0, 1);  // second pass
        vecs[16] = mk(0, 0, 1,  1, 1, 0, 1, 0, 1);
        vecs[17] = mk(0, 0, 1,  1, 2, 0, 1, 0, 1);
        vecs[18] = mk(0, 0, 1,  1, 3, 0, 1, 0, 1);
        vecs[19] = mk(0, 1, 1,  0, 0, 0, 0, 0, 1);  // clear at addr=3
        vecs[20] = mk(0, 0, 1,  0, 0, 0, 0, 0, 1);  // no done pulse
        vecs[21] = mk(1, 0, 1,  1, 0, 0, 1, 0, 1);  // restart from 0
        vecs[22] = mk(0, 0, 1,  1, 1, 0, 1, 0, 1);
        vecs[23] = mk(0, 0, 1,  1, 2, 0, 1, 0, 1);
        vecs[24] = mk(0, 0, 1,  1, 3, 0, 1, 0, 1);
        vecs[25] = mk(0, 0, 1,  1, 4, 0, 1, 0, 1);
        vecs[26] = mk(0, 0, 1,  1, 5, 1, 1, 0, 1);
        vecs[27] = mk(0, 0, 1,  0, 5, 0, 1, 1, 2);

        // ---------------- reset with random inputs ----------------
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f_start = 1'($urandom); f_clear = 1'($urandom); f_ready = 1'($urandom);
            a_start = 1'($urandom); a_clear = 1'($urandom); a_ready = 1'($urandom);
            z_start = 1'($urandom); z_clear = 1'($urandom); z_ready = 1'($urandom);
            tick();
        end
        chk("reset_full", f_obs, '0);
        chk("reset_l5",   a_obs, '0);
        chk("reset_l0",   z_obs, '0);
        f_start = 0; f_clear = 0; f_ready = 1;
        a_start = 0; a_clear = 0; a_ready = 0;
        z_start = 0; z_clear = 0; z_ready = 1;
        reset = 1'b1;
        tick();
        chk("idle_after_reset", f_obs, '0);

        // ---------------- full pass, LAST=1023 ----------------
        f_start = 1;
        tick();
        f_start = 0;
        for (int i = 0; i <= 1023; i++) begin
            chk($sformatf("full_addr%0d", i), f_obs,
                pk(1, i, (i == 1023), 1, 0, 0));
            tick();
        end
        $display("full pass: addresses 0..1023 walked");
        chk("full_done", f_obs, pk(0, 1023, 0, 1, 1, 1));
        tick();
        chk("full_idle", f_obs, pk(0, 0, 0, 0, 0, 1));

        // ---------------- table: back-pressure, clear, ignored start -----
        for (int i = 0; i < 28; i++) begin
            a_start = vecs[i].st;
            a_clear = vecs[i].cl;
            a_ready = vecs[i].rdy;
            tick();
            $display("vec %0d st=%0b cl=%0b rdy=%0b -> v=%0b addr=%0d last=%0b busy=%0b done=%0b fcnt=%0d",
                     i, vecs[i].st, vecs[i].cl, vecs[i].rdy,
                     a_valid, a_addr, a_last, a_busy, a_done, a_fcnt);
            chk($sformatf("l5_vec%0d", i), a_obs,
                pk(vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_last,
                   vecs[i].e_busy, vecs[i].e_done, vecs[i].e_fcnt));
        end
        a_start = 0; a_clear = 0; a_ready = 0;

        // ---------------- LAST=0 single beats, FCNT_W=2 wrap ----------------
        for (int p = 1; p <= 5; p++) begin
            z_start = 1;
            tick();
            chk($sformatf("l0_beat_p%0d", p), z_obs, pk(1, 0, 1, 1, 0, (p - 1) % 4));
            tick();                      // start still high through RUN/DONE
            chk($sformatf("l0_done_p%0d", p), z_obs, pk(0, 0, 0, 1, 1, p % 4));
            z_start = 0;
            tick();
            chk($sformatf("l0_idle_p%0d", p), z_obs, pk(0, 0, 0, 0, 0, p % 4));
            $display("l0 pass %0d fcnt=%0d", p, z_fcnt);
        end

        // ---------------- asynchronous reset mid-RUN ----------------
        f_start = 1;
        tick();
        f_start = 0;
        repeat (37) tick();
        chk("full_at37", f_obs, pk(1, 37, 0, 1, 0, 1));
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_full", f_obs, '0);
        chk("async_reset_l5",   a_obs, '0);
        chk("async_reset_l0",   z_obs, '0);
        tick();
        chk("reset_held", f_obs, '0);
        reset = 1'b1;
        f_start = 1;
        tick();
        f_start = 0;
        chk("first_start_after_reset", f_obs, pk(1, 0, 0, 1, 0, 0));
        tick();
        chk("second_beat_after_reset", f_obs, pk(1, 1, 0, 1, 0, 0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
